// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: data-memory req/ack bus between the memory stage and data memory
interface mem_stage_ctrl_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_ack;
   modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack);
   modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage load/store sequencing, stall, write-back and SIIC/RTI redirect
module mem_stage_ctrl #(
   parameter int          WAIT_MAX = 15,
   parameter logic [15:0] ISR_VEC  = 16'h0002
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       exmem_alu,
   input  logic [15:0]       exmem_b,
   input  logic [15:0]       exmem_nxt_pc,
   input  logic [2:0]        exmem_dst,
   input  logic              exmem_memtoreg,
   input  logic              exmem_memwrite,
   input  logic              exmem_regwrite,
   input  logic              exmem_enjal,
   input  logic              exmem_halt,
   input  logic              exmem_siic,
   input  logic              exmem_rti,
   mem_stage_ctrl_if.master  dmem,
   output logic              stall,
   output logic [15:0]       wb_data,
   output logic [2:0]        wb_dst,
   output logic              wb_regwrite,
   output logic              wb_halt,
   output logic              mem_err,
   output logic              redirect,
   output logic [15:0]       redirect_pc,
   output logic [15:0]       epc
);
   localparam int CW = $clog2(WAIT_MAX + 1);
   typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
   state_t        state_q, state_d;
   logic [15:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic          we_q, we_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   wb_data_q, wb_data_d, redirect_pc_q, redirect_pc_d, epc_q, epc_d;
   logic [2:0]    wb_dst_q, wb_dst_d;
   logic          wb_regwrite_q, wb_regwrite_d, wb_halt_q, wb_halt_d;
   logic          mem_err_q, mem_err_d, redirect_q, redirect_d;
   logic          memop, stall_c, adv;
   // Next-state: access sequencing, timeout, write-back and redirect
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      we_d          = we_q;
      rdata_d       = rdata_q;
      cnt_d         = cnt_q;
      wb_data_d     = wb_data_q;
      wb_dst_d      = wb_dst_q;
      wb_regwrite_d = 1'b0;
      wb_halt_d     = wb_halt_q;
      mem_err_d     = mem_err_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      epc_d         = epc_q;
      memop   = exmem_memtoreg | exmem_memwrite;
      stall_c = (state_q == IDLE && memop) || (state_q == WAIT && !dmem.dmem_ack);
      adv     = !stall_c && state_q != HALTED;
      if (state_q == IDLE && memop) begin
         addr_d  = exmem_alu;
         wdata_d = exmem_b;
         we_d    = exmem_memwrite;
         cnt_d   = '0;
         state_d = WAIT;
      end
      if (state_q == WAIT) begin
         if (dmem.dmem_ack) begin
            rdata_d = dmem.dmem_rdata;
            state_d = IDLE;
         end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
            mem_err_d = 1'b1;
            wb_halt_d = 1'b1;
            state_d   = HALTED;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (adv) begin
         wb_dst_d      = exmem_dst;
         wb_regwrite_d = exmem_regwrite & ~exmem_memwrite;
         wb_data_d     = exmem_enjal ? exmem_nxt_pc :
                         exmem_memtoreg ? (state_q == WAIT ? dmem.dmem_rdata : rdata_q) : exmem_alu;
         if (exmem_halt) begin
            wb_halt_d = 1'b1;
            state_d   = HALTED;
         end
         if (exmem_siic) begin
            epc_d         = exmem_nxt_pc;
            redirect_d    = 1'b1;
            redirect_pc_d = ISR_VEC;
         end else if (exmem_rti) begin
            redirect_d    = 1'b1;
            redirect_pc_d = epc_q;
         end
      end
   end
   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         we_q          <= 1'b0;
         rdata_q       <= '0;
         cnt_q         <= '0;
         wb_data_q     <= '0;
         wb_dst_q      <= '0;
         wb_regwrite_q <= 1'b0;
         wb_halt_q     <= 1'b0;
         mem_err_q     <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         epc_q         <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         we_q          <= we_d;
         rdata_q       <= rdata_d;
         cnt_q         <= cnt_d;
         wb_data_q     <= wb_data_d;
         wb_dst_q      <= wb_dst_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_halt_q     <= wb_halt_d;
         mem_err_q     <= mem_err_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         epc_q         <= epc_d;
      end
   end
   // Stall is masked during reset so the pipeline enable is released immediately
   assign stall           = stall_c & ~rst;
   assign dmem.dmem_req   = state_q == WAIT;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign wb_data         = wb_data_q;
   assign wb_dst          = wb_dst_q;
   assign wb_regwrite     = wb_regwrite_q;
   assign wb_halt         = wb_halt_q;
   assign mem_err         = mem_err_q;
   assign redirect        = redirect_q;
   assign redirect_pc     = redirect_pc_q;
   assign epc             = epc_q;
endmodule
